pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and fetch sequencer for the RISCV32I core; sits directly upstream of
//  the PC Adder. Drives the current PC into the Adder (in1, sel=1) and takes back PC+4.
//  Selects next PC (sequential / branch-jump redirect), handles stall, and runs a req/ready
//  handshake to instruction memory. Delivers {fetch_valid, fetch_pc} to decode.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; must be word-aligned
//  CNT_W      32             width of the accepted-fetch performance counter
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  stall          in   1      hazard stall from pipeline control; hold PC, drop request
//  branch_taken   in   1      redirect request (taken branch / JAL / JALR) from EX
//  branch_target  in   32     redirect address; valid when branch_taken=1
//  pc_plus4_in    in   32     Adder output (pc_out + 4)
//  imem_ready     in   1      instruction memory accepts the current request this cycle
//  pc_out         out  32     current PC; to Adder in1 and imem address
//  imem_req       out  1      fetch request; address = pc_out
//  fetch_valid    out  1      registered one-cycle pulse: a fetch completed
//  fetch_pc       out  32     PC of the completed fetch; valid with fetch_valid
//  misalign_err   out  1      sticky: redirect target not word-aligned
//  fetch_count    out  CNT_W  number of completed fetches since reset, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (async on rst_n=0): pc_out=RESET_PC, state=BOOT, imem_req=0, fetch_valid=0,
//   fetch_pc=0, misalign_err=0, fetch_count=0. Reset mid-handshake aborts it; no fetch_valid.
//  Reset is released synchronously. Releasing it mid-cycle must not glitch the outputs.
//  States: BOOT, FETCH, STALL, ERROR. State register is binary encoded.
//   BOOT : one cycle after rst_n rises; imem_req=0; -> FETCH.
//   FETCH: imem_req=1 unless stall=1 or branch_taken=1 (imem_req is combinational on these).
//   STALL: entered when stall=1 in FETCH; imem_req=0; pc held; stall=0 -> FETCH.
//   ERROR: entered on a misaligned redirect; imem_req=0; pc held; exit only by reset.
//  Per-cycle priority in FETCH/STALL: branch_taken > stall > imem_ready.
//   branch_taken=1, target[1:0]==0: pc<=branch_target, next state FETCH (even if stall=1).
//     A handshake in the same cycle (imem_ready=1) is discarded: no fetch_valid, no count.
//   branch_taken=1, target[1:0]!=0: misalign_err<=1, state<=ERROR, pc unchanged.
//   stall=1 (no branch): pc held, no handshake completes, next state STALL.
//   FETCH & imem_req & imem_ready: pc<=pc_plus4_in; next cycle fetch_valid=1,
//     fetch_pc=old pc; fetch_count+=1.
//   FETCH & imem_ready=0: pc and request held stable (request never withdrawn except by
//     stall/branch).
//  Latency: one request accepted per cycle max; ready held high gives back-to-back
//   fetch_valid with PCs +4 apart.
//  Arithmetic: PC wrap 32'hFFFF_FFFC -> 32'h0 through the Adder; accepted without error.
//   fetch_count wraps silently.
//  fetch_valid is a pulse: deasserted every cycle without a new completion.
//  branch_taken in BOOT or ERROR is ignored.
// TESTING
//  T1 reset: RESET_PC=0, release rst_n, ready=1 -> fetch_valid pulses with fetch_pc 0,4,8,C;
//     fetch_count=4 after 4 fetches.
//  T2 memory wait: ready=0 for 3 cycles at pc=8 -> imem_req=1, pc_out=8 held;
//     ready=1 -> fetch_pc=8, then pc_out=C.
//  T3 stall: stall=1 for 2 cycles at pc=10 -> imem_req=0, no fetch_valid, pc_out=10;
//     release -> fetch of 10 completes.
//  T4 redirect with ready: branch_taken=1, target=0x100, ready=1 at pc=14 -> no fetch_valid
//     for 14; next fetch_pc=0x100, then 0x104.
//  T5 branch during stall: stall=1, branch_taken=1, target=0x40 -> pc_out=0x40, FETCH;
//     misaligned target 0x42 -> misalign_err=1, imem_req=0 until rst_n low.
//  T6 async reset mid-wait: drop rst_n between edges while req=1 -> outputs reset
//     immediately; pc wrap check at 32'hFFFF_FFFC -> next fetch_pc=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//   Program-counter register and fetch sequencer for the RISCV32I core.
//   Drives the current PC to the PC Adder and instruction memory, takes
//   PC+4 back from the Adder, and picks the next PC. The next PC is either
//   the sequential PC+4 or a branch/jump redirect target. It also handles
//   pipeline stalls and runs a req/ready handshake with instruction memory.
//   Each completed fetch is reported to decode as a one-cycle
//   {fetch_valid, fetch_pc} pulse.
//
// Ports
//   clk            in   1      system clock, rising edge
//   rst_n          in   1      asynchronous active-low reset
//   stall          in   1      hazard stall: hold PC, drop request
//   branch_taken   in   1      redirect request from EX
//   branch_target  in   32     redirect address (valid with branch_taken)
//   pc_plus4_in    in   32     Adder result, pc_out + 4
//   imem_ready     in   1      imem accepts the current request
//   pc_out         out  32     current PC (Adder in1, imem address)
//   imem_req       out  1      fetch request, address = pc_out
//   fetch_valid    out  1      one-cycle pulse: a fetch completed
//   fetch_pc       out  32     PC of the completed fetch
//   misalign_err   out  1      sticky: misaligned redirect target seen
//   fetch_count    out  CNT_W  completed fetches since reset (wraps)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      pc_plus4_in,
  input  logic             imem_ready,
  output logic [31:0]      pc_out,
  output logic             imem_req,
  output logic             fetch_valid,
  output logic [31:0]      fetch_pc,
  output logic             misalign_err,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_d;
  logic        misalign_d;
  logic        accept;

  // Next-state, next-PC and request logic. Priority while FETCH/STALL:
  // branch_taken > stall > imem_ready. A redirect discards any handshake
  // offered in the same cycle, because imem_req is low whenever
  // branch_taken is high.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    pc_d       = pc_out;
    misalign_d = misalign_err;
    imem_req   = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      BOOT:  state_d = FETCH;
      FETCH,
      STALL: begin
        if (branch_taken) begin
          if (branch_target[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = ERROR;
          end else begin
            pc_d    = branch_target;
            state_d = FETCH;
          end
        end else if (stall) begin
          state_d = STALL;
        end else if (state_q == STALL) begin
          // The first cycle after a stall releases the stall but does not
          // request yet. Requesting resumes once the state is back in FETCH.
          state_d = FETCH;
        end else begin
          imem_req = 1'b1;
          if (imem_ready) begin
            accept = 1'b1;
            pc_d   = pc_plus4_in;
          end
        end
      end
      ERROR: ;  // held until reset; redirects are ignored here
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_out       <= RESET_PC;
      fetch_valid  <= 1'b0;
      fetch_pc     <= 32'h0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q      <= state_d;
      pc_out       <= pc_d;
      misalign_err <= misalign_d;
      fetch_valid  <= accept;
      if (accept) begin
        fetch_pc    <= pc_out;
        fetch_count <= fetch_count + CNT_W'(1);
      end
    end
  end

endmodule
